mips_multicycle_ctrl: RTL

Multi-cycle control FSM for the 8-bit MIPS core. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the 1-bit alu_op into the ALU control decoder: 0 passes funct, 1 forces ADD (3'b001). It also drives register-file, memory and PC enables, and handshakes with a memory port that may stall.

---
 rtl/mips_multicycle_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS core: sequences fetch/decode/execute/memory/writeback,
// handshakes with a stallable memory port and flags illegal opcodes or memory timeouts.
module mips_multicycle_ctrl #(
  parameter int ILLEGAL_HALT = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       eq,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_op,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       busy,
  output logic       err,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [3:0] tmo_cnt;
  logic       tmo_hit;
  logic       retire;
  logic       set_err;

  // Last wait cycle: an ack here still succeeds, silence means timeout.
  assign tmo_hit = (tmo_cnt == 4'(MEM_TIMEOUT - 1));
  assign busy    = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= 3'b000;
      tmo_cnt     <= 4'd0;
      err         <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        op_q <= opcode;
      if (state_nxt != state)
        tmo_cnt <= 4'd0;
      else if (state == S_FETCH || state == S_MEM)
        tmo_cnt <= tmo_cnt + 4'd1;
      if (set_err)
        err <= 1'b1;
      if (retire)
        instr_count <= instr_count + 8'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    set_err    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 1'b0;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_op    = 1'b1;
          alu_src_b = 2'b01;
          state_nxt = S_DECODE;
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_R: state_nxt = S_WB;
          OP_ADDI: begin
            alu_op    = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op    = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = S_MEM;
          end
          OP_BEQ: begin
            pc_src   = 2'b01;
            pc_write = eq;
            retire   = 1'b1;
          end
          OP_J: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          default: begin
            if (ILLEGAL_HALT != 0) begin
              set_err   = 1'b1;
              state_nxt = S_HALT;
            end else begin
              retire = 1'b1;
            end
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (mem_ack) begin
          if (op_q == OP_SW) retire = 1'b1;
          else               state_nxt = S_WB;
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    // run is only consulted at an instruction boundary.
    if (retire)
      state_nxt = run ? S_FETCH : S_IDLE;
  end

endmodule
